// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and types for the ALU op scheduler.
//   - opcode values carried on req*_op
//   - scheduler FSM state enum
//   - datapath unit indices (bit positions in the dp_* per-unit flag vectors)
//   - demux/mux, bitwise and shifter select encodings
//   - bit positions of rsp_flags = {zero, negative, overflow, cout}
package alu_ctrl_pkg;

  localparam int DW  = 16;
  localparam int SHW = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHA = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_BITW  = 2'd1;
  localparam logic [1:0] UNIT_SHIFT = 2'd2;

  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_BITW  = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  localparam logic [1:0] BIT_AND = 2'b00;
  localparam logic [1:0] BIT_OR  = 2'b01;
  localparam logic [1:0] BIT_XOR = 2'b10;

  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_SHA = 2'b10;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 3;

  // Latched operation.
  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          id;
  } req_t;

  function automatic logic is_shift(logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SHA);
  endfunction

  function automatic logic [3:0] mk_flags(logic z, logic n, logic v, logic c);
    logic [3:0] f;
    f            = '0;
    f[FLAG_ZERO] = z;
    f[FLAG_NEG]  = n;
    f[FLAG_OVF]  = v;
    f[FLAG_COUT] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   en         : arbitration allowed this cycle (scheduler idle)
//   valid[1:0] : request valids
//   grant[1:0] : one-hot grant (zero when !en or no valid)
// Every grant is a handshake (ready == grant), so the pointer moves on any grant.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Index granted most recently; resets to 1 so req0 wins the first tie.
  logic last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (&valid) grant = last ? 2'b01 : 2'b10;
      else        grant = valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (|grant) last <= grant[1];
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: accepts ops from two requesters, drives the external
// 16-bit datapath selects, iterates the 1-bit shifter for multi-bit shifts,
// and returns a registered result/flags/id over a valid/ready response.
//   req{0,1}_valid/ready/op/a/b : request channels
//   rsp_valid/ready/id/result/flags : response channel, flags = {z,n,v,c}
//   busy : FSM not idle
//   dp_* outputs : datapath operands and selects (none/zero when unused)
//   dp_c, dp_{cout,overflow,negative,zero} : datapath result and per-unit flags
module alu_op_scheduler
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic [3:0]    rsp_flags,
  output logic          busy,
  output logic [DW-1:0] dp_a,
  output logic [DW-1:0] dp_b,
  output logic [1:0]    dp_sel1,
  output logic [1:0]    dp_sel2,
  output logic          dp_op_add_sub,
  output logic [1:0]    dp_select_bit,
  output logic [1:0]    dp_shift_op,
  input  logic [DW-1:0] dp_c,
  input  logic [2:0]    dp_cout,
  input  logic [2:0]    dp_overflow,
  input  logic [2:0]    dp_negative,
  input  logic [2:0]    dp_zero
);

  state_e         state;
  req_t           cur;
  req_t           nreq;
  logic [SHW-1:0] cnt;
  logic [DW-1:0]  work;
  logic [1:0]     grant;
  logic [1:0]     unit;
  logic           in_exec;
  logic           unused_shift_flags;

  // Shift flags are rebuilt from the final result, so the shifter's own flags
  // are deliberately ignored.
  assign unused_shift_flags = ^{dp_cout[UNIT_SHIFT], dp_overflow[UNIT_SHIFT],
                                dp_negative[UNIT_SHIFT], dp_zero[UNIT_SHIFT]};

  // rst_n gates the grant so ready stays low while reset is held.
  alu_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state == ST_IDLE) && rst_n),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = (state != ST_IDLE);
  assign in_exec    = (state == ST_EXEC) || (state == ST_SHIFT);
  assign unit       = ((cur.op == OP_ADD) || (cur.op == OP_SUB)) ? UNIT_ARITH : UNIT_BITW;

  always_comb begin
    nreq = '0;
    if (grant[1]) begin
      nreq.op = req1_op; nreq.a = req1_a; nreq.b = req1_b; nreq.id = 1'b1;
    end else begin
      nreq.op = req0_op; nreq.a = req0_a; nreq.b = req0_b; nreq.id = 1'b0;
    end
  end

  // Datapath controls come only from latched state, never from req_* inputs.
  always_comb begin
    dp_sel1       = SEL_NONE;
    dp_sel2       = SEL_NONE;
    dp_a          = '0;
    dp_b          = '0;
    dp_op_add_sub = 1'b0;
    dp_select_bit = 2'b00;
    dp_shift_op   = 2'b00;
    if (in_exec) begin
      case (cur.op)
        OP_ADD, OP_SUB: begin
          dp_sel1 = SEL_ARITH; dp_sel2 = SEL_ARITH;
          dp_a = cur.a; dp_b = cur.b;
          dp_op_add_sub = (cur.op == OP_ADD);
        end
        OP_AND, OP_OR, OP_XOR: begin
          dp_sel1 = SEL_BITW; dp_sel2 = SEL_BITW;
          dp_a = cur.a; dp_b = cur.b;
          dp_select_bit = (cur.op == OP_AND) ? BIT_AND :
                          (cur.op == OP_OR)  ? BIT_OR  : BIT_XOR;
        end
        default: begin
          // Zero-amount shifts bypass the datapath entirely.
          if (cnt != '0) begin
            dp_sel1 = SEL_SHIFT; dp_sel2 = SEL_SHIFT;
            dp_a = work; dp_b = cur.b;
            dp_shift_op = (cur.op == OP_SHL) ? SH_SHL :
                          (cur.op == OP_SHR) ? SH_SHR : SH_SHA;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      cnt        <= '0;
      work       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            cur   <= nreq;
            cnt   <= nreq.b[SHW-1:0];
            work  <= nreq.a;
            state <= ST_EXEC;
          end
        end
        ST_EXEC, ST_SHIFT: begin
          if (!is_shift(cur.op)) begin
            rsp_result <= dp_c;
            rsp_flags  <= mk_flags(dp_zero[unit], dp_negative[unit],
                                   dp_overflow[unit], dp_cout[unit]);
            rsp_id     <= cur.id;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else if (cnt == '0) begin
            rsp_result <= cur.a;
            rsp_flags  <= mk_flags(cur.a == '0, cur.a[DW-1], 1'b0, 1'b0);
            rsp_id     <= cur.id;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            work <= dp_c;
            cnt  <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              rsp_result <= dp_c;
              rsp_flags  <= mk_flags(dp_c == '0, dp_c[DW-1], 1'b0, 1'b0);
              rsp_id     <= cur.id;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
